// File: rtl/io_line_pkg.sv
// Shared types and defaults for the io_line_bank short-line track bank.
// Also carries the command legality check used when a command is latched.
package io_line_pkg;

    localparam int WORD_BITS_DEF = 29;
    localparam int WORDS_DEF     = 4;
    localparam int NCH_DEF       = 3;
    localparam int CH_W          = 3;
    localparam int WORD_W        = 7;
    localparam int REM_W         = 8;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COPY  = 2'd2,
        OP_OR    = 2'd3
    } op_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ARM    = 2'd1;
    localparam state_t ST_ACTIVE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    typedef struct packed {
        op_t               op;
        logic [CH_W-1:0]   ch;
        logic [CH_W-1:0]   src;
        logic [WORD_W-1:0] word;
        logic              all;
        logic              bad;
    } cmd_t;

    function automatic logic cmd_illegal(
        input op_t               op,
        input logic [CH_W-1:0]   ch,
        input logic [CH_W-1:0]   src,
        input logic [WORD_W-1:0] word,
        input logic              all,
        input int                nch,
        input int                words
    );
        logic bad;
        bad = 1'b0;
        if (int'(ch) >= nch)
            bad = 1'b1;
        if (op == OP_COPY && int'(src) >= nch)
            bad = 1'b1;
        if (!all && int'(word) >= words)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/io_line_bank_track.sv
// One recirculating drum line: LEN-bit serial shift register, cleared by reset.
// A bit entering at din reappears at dout exactly LEN cycles later.
module line_track #(
    parameter int LEN = 116
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [LEN-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr_q <= '0;
        else
            sr_q <= {sr_q[LEN-2:0], din};
    end

    assign dout = sr_q[LEN-1];

endmodule

// File: rtl/io_line_bank.sv
// Bank of NCH recirculating lines with a queued word-addressed command engine.
// Optional feature: define IO_LINE_MARKER_EN for the AUTO reload marker on channel 0.
module io_line_bank
    import io_line_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int WORDS     = WORDS_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              T0,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [CH_W-1:0]   cmd_src,
    input  logic [WORD_W-1:0] cmd_word,
    input  logic              cmd_all,
    input  logic              sin,
    input  logic              AUTO,
    output logic [NCH-1:0]    dout,
    output logic              sout,
    output logic [WORD_W-1:0] word_pos,
    output logic              done,
    output logic              err
);

    localparam int                L         = WORDS * WORD_BITS;
    localparam int                BC_W      = $clog2(WORD_BITS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);
    localparam logic [REM_W-1:0]  REM_ALL   = REM_W'(WORDS);

    state_t              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [WORD_W-1:0]   word_pos_q, word_pos_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [NCH-1:0]      din;
    logic [NCH-1:0]      mark_vec;
    logic [7:0]          dout_pad;
    logic                wr_bit;
    logic                active;

    // Frame counters: T0 closes a word, so the cycle after T0 is bit 0 of the next word.
    always_comb begin
        word_pos_d = word_pos_q;
        bit_cnt_d  = bit_cnt_q + 1'b1;
        if (T0) begin
            bit_cnt_d  = '0;
            word_pos_d = (word_pos_q == LAST_WORD) ? '0 : word_pos_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = '{op:   op_t'(cmd_op),
                              ch:   cmd_ch,
                              src:  cmd_src,
                              word: cmd_word,
                              all:  cmd_all,
                              bad:  cmd_illegal(op_t'(cmd_op), cmd_ch, cmd_src,
                                                cmd_word, cmd_all, NCH, WORDS)};
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // An illegal command only passes through here for one cycle.
                if (cmd_q.bad) begin
                    state_d = ST_DONE;
                end else if (T0 && (cmd_q.all || word_pos_d == cmd_q.word)) begin
                    state_d = ST_ACTIVE;
                    rem_d   = cmd_q.all ? REM_ALL : REM_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (T0) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == REM_W'(1))
                        state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            rem_q      <= '0;
            word_pos_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            rem_q      <= rem_d;
            word_pos_q <= word_pos_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign active = (state_q == ST_ACTIVE);

    always_comb begin
        dout_pad          = '0;
        dout_pad[NCH-1:0] = dout;
        case (cmd_q.op)
            OP_CLEAR: wr_bit = 1'b0;
            OP_LOAD:  wr_bit = sin;
            OP_COPY:  wr_bit = dout_pad[cmd_q.src];
            OP_OR:    wr_bit = dout_pad[cmd_q.ch] | sin;
            default:  wr_bit = 1'b0;
        endcase
    end

`ifdef IO_LINE_MARKER_EN
    // Marker is ORed after the command mux so it survives a CLEAR of channel 0.
    logic marker;
    assign marker   = AUTO && !word_pos_q[0] && (bit_cnt_q == BC_W'(1));
    assign mark_vec = NCH'(marker);
`else
    logic unused_marker;
    assign unused_marker = ^{AUTO, bit_cnt_q};
    assign mark_vec      = '0;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic sel;
        assign sel    = active && (cmd_q.ch == CH_W'(c));
        assign din[c] = (sel ? wr_bit : dout[c]) | mark_vec[c];

        line_track #(.LEN(L)) u_trk (
            .clk  (CLOCK),
            .rst  (rst),
            .din  (din[c]),
            .dout (dout[c])
        );
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = done && cmd_q.bad;
    assign sout      = active ? dout_pad[cmd_q.ch] : 1'b0;
    assign word_pos  = word_pos_q;

endmodule

// File: tb/tb_io_line_bank.sv
// Directed bench for io_line_bank: frame model, command latency and track contents.
module tb_io_line_bank;
    import io_line_pkg::*;

    localparam int NCH = 3, WORDS = 4, WB = 29, L = WORDS * WB;

    logic CLOCK = 1'b0, rst = 1'b1, T0 = 1'b0, cmd_valid = 1'b0;
    logic cmd_all = 1'b0, sin = 1'b0, AUTO = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_ch = 3'd0, cmd_src = 3'd0;
    logic [6:0] cmd_word = 7'd0;
    logic cmd_ready, sout, done, err;
    logic [NCH-1:0] dout;
    logic [6:0] word_pos;

    int errors = 0, checks = 0;
    int mb = 0, mw = 0, cyc = 0;
    logic [28:0] sin_pat = '0;
    logic [28:0] exp_trk [NCH][WORDS];
    logic [28:0] cap [NCH][WORDS];

    always #5 CLOCK = ~CLOCK;

    io_line_bank #(.NCH(NCH), .WORDS(WORDS), .WORD_BITS(WB)) dut (
        .CLOCK(CLOCK), .rst(rst), .T0(T0), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_src(cmd_src), .cmd_word(cmd_word),
        .cmd_all(cmd_all), .sin(sin), .AUTO(AUTO), .dout(dout), .sout(sout),
        .word_pos(word_pos), .done(done), .err(err)
    );

    // Frame generator: mb/mw are the bench's own word/bit position of the current cycle.
    initial begin
        forever begin
            @(posedge CLOCK); #1;
            cyc++;
            if (rst) begin mb = 0; mw = 0; end
            else if (T0) begin mb = 0; mw = (mw + 1) % WORDS; end
            else mb++;
            T0  = (mb == WB - 1);
            sin = sin_pat[mb];
        end
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] ch, input logic [2:0] src,
                         input int w, input logic all, input bit on_t0,
                         output int acyc, output int amb, output int weff);
        int guard;
        guard = 0;
        @(posedge CLOCK); #2;
        while ((T0 !== on_t0 || cmd_ready !== 1'b1) && guard < 200) begin
            @(posedge CLOCK); #2; guard++;
        end
        if (guard >= 200) begin
            errors++;
            $display("FAIL issue_wait: cmd_ready=%b T0=%b never reached required state", cmd_ready, T0);
        end
        weff     = (w < 0) ? (mw + 1) % WORDS : w;
        cmd_op   = op; cmd_ch = ch; cmd_src = src;
        cmd_word = 7'(weff); cmd_all = all; cmd_valid = 1'b1;
        acyc = cyc; amb = mb;
        @(posedge CLOCK); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output logic derr,
                             output int dmw, output int dmb, output int ones);
        dcyc = -1; derr = 1'b0; dmw = 0; dmb = 0; ones = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK);
            if (sout === 1'b1) ones++;
            if (done === 1'b1) begin
                dcyc = cyc; derr = err; dmw = mw; dmb = mb;
                break;
            end
        end
        checks++;
        if (dcyc < 0) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end else begin
            @(negedge CLOCK);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: done=%b one cycle later, expected 0", done);
            end
        end
    endtask

    task automatic check_tracks(input string nm);
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < WORDS; w++) cap[c][w] = '0;
        repeat (L) begin
            @(negedge CLOCK);
            for (int c = 0; c < NCH; c++) cap[c][mw][mb] = dout[c];
        end
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < WORDS; w++) begin
                checks++;
                if (cap[c][w] !== exp_trk[c][w]) begin
                    errors++;
                    $display("FAIL %s ch%0d w%0d: got %h expected %h", nm, c, w, cap[c][w], exp_trk[c][w]);
                end
            end
    endtask

    task automatic test_reset;
        int bad, wraps;
        logic [6:0] prev;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        checks += 6;
        if (dout !== '0)       begin errors++; $display("FAIL rst_dout: got %b expected 0", dout); end
        if (word_pos !== 7'd0) begin errors++; $display("FAIL rst_word_pos: got %0d expected 0", word_pos); end
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        if (done !== 1'b0)     begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        if (err !== 1'b0)      begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        if (sout !== 1'b0)     begin errors++; $display("FAIL rst_sout: got %b expected 0", sout); end
        rst = 1'b0;
        bad = 0; wraps = 0; prev = 7'd0;
        repeat (200) begin
            @(negedge CLOCK);
            if (dout !== '0 || word_pos !== 7'(mw)) bad++;
            if (prev == 7'd3 && word_pos == 7'd0) wraps++;
            prev = word_pos;
        end
        checks += 2;
        if (bad != 0)   begin errors++; $display("FAIL idle_frame: %0d bad cycles, expected 0", bad); end
        if (wraps != 1) begin errors++; $display("FAIL word_pos_wrap: got %0d wraps expected 1", wraps); end
    endtask

    task automatic test_load;
        int a, amb, we, dc, dmw, dmb, ones;
        logic de;
        sin_pat = 29'h1555_5555;
        issue(OP_LOAD, 3'd1, 3'd0, 2, 1'b0, 1'b0, a, amb, we);
        wait_done(400, dc, de, dmw, dmb, ones);
        checks += 2;
        if (de !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", de); end
        if (dmw != 3 || dmb != 0) begin
            errors++; $display("FAIL load_done_slot: got w%0d b%0d expected w3 b0", dmw, dmb);
        end
        exp_trk[1][2] = 29'h1555_5555;
        check_tracks("load");
    endtask

    task automatic test_or;
        int a, amb, we, dc, dmw, dmb, ones;
        logic de;
        sin_pat = 29'h0AAA_AAAA;
        issue(OP_OR, 3'd1, 3'd0, 2, 1'b0, 1'b0, a, amb, we);
        wait_done(400, dc, de, dmw, dmb, ones);
        checks += 2;
        if (ones != 15) begin errors++; $display("FAIL or_sout_ones: got %0d expected 15", ones); end
        if (dmw != 3 || dmb != 0) begin
            errors++; $display("FAIL or_done_slot: got w%0d b%0d expected w3 b0", dmw, dmb);
        end
        exp_trk[1][2] = 29'h1FFF_FFFF;
        check_tracks("or");
    endtask

    task automatic test_copy_all;
        int a, amb, we, dc, dmw, dmb, ones;
        logic de;
        sin_pat = '0;
        issue(OP_COPY, 3'd2, 3'd1, 0, 1'b1, 1'b0, a, amb, we);
        wait_done(400, dc, de, dmw, dmb, ones);
        checks++;
        if (dc != a + (WB - 1 - amb) + L + 1) begin
            errors++; $display("FAIL copy_all_latency: done at +%0d expected +%0d", dc - a, (WB - 1 - amb) + L + 1);
        end
        for (int w = 0; w < WORDS; w++) exp_trk[2][w] = exp_trk[1][w];
        check_tracks("copy_all");
    endtask

    task automatic test_copy_self;
        int a, amb, we, dc, dmw, dmb, ones;
        logic de;
        issue(OP_COPY, 3'd1, 3'd1, 2, 1'b0, 1'b0, a, amb, we);
        wait_done(400, dc, de, dmw, dmb, ones);
        checks++;
        if (de !== 1'b0) begin errors++; $display("FAIL copy_self_err: got %b expected 0", de); end
        check_tracks("copy_self");
    endtask

    task automatic test_t0_accept;
        int a, amb, we, dc, dmw, dmb, ones;
        logic de;
        sin_pat = 29'h00AB_CDEF;
        issue(OP_LOAD, 3'd0, 3'd0, -1, 1'b0, 1'b1, a, amb, we);
        wait_done(400, dc, de, dmw, dmb, ones);
        checks++;
        if (dc != a + L + WB + 1) begin
            errors++; $display("FAIL t0_accept_latency: done at +%0d expected +%0d", dc - a, L + WB + 1);
        end
        exp_trk[0][we] = 29'h00AB_CDEF;
        check_tracks("t0_accept");
    endtask

    task automatic test_illegal;
        int a, amb, we;
        logic [1:0] op;
        logic [2:0] ch, src;
        int w;
        for (int v = 0; v < 3; v++) begin
            case (v)
                0: begin op = OP_LOAD;  ch = 3'd5; src = 3'd0; w = 1; end
                1: begin op = OP_COPY;  ch = 3'd0; src = 3'd3; w = 1; end
                default: begin op = OP_CLEAR; ch = 3'd1; src = 3'd0; w = 4; end
            endcase
            sin_pat = 29'h1FFF_FFFF;
            issue(op, ch, src, w, 1'b0, 1'b0, a, amb, we);
            @(negedge CLOCK);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL illegal%0d_early: done=%b at +1 expected 0", v, done); end
            @(negedge CLOCK);
            checks++;
            if (done !== 1'b1 || err !== 1'b1) begin
                errors++; $display("FAIL illegal%0d_done_err: done=%b err=%b at +2 expected 1 1", v, done, err);
            end
        end
        check_tracks("illegal");
    endtask

`ifdef IO_LINE_MARKER_EN
    task automatic test_marker;
        int a, amb, we, dc, dmw, dmb, ones;
        logic de;
        AUTO = 1'b1;
        issue(OP_CLEAR, 3'd0, 3'd0, 0, 1'b1, 1'b0, a, amb, we);
        wait_done(400, dc, de, dmw, dmb, ones);
        AUTO = 1'b0;
        exp_trk[0][0] = 29'h2; exp_trk[0][1] = '0;
        exp_trk[0][2] = 29'h2; exp_trk[0][3] = '0;
        check_tracks("marker");
    endtask
`endif

    task automatic test_rst_mid;
        int a, amb, we, seen;
        sin_pat = 29'h1FFF_FFFF;
        issue(OP_LOAD, 3'd1, 3'd0, 0, 1'b1, 1'b0, a, amb, we);
        while (cyc < a + (WB - 1 - amb) + 40) begin @(posedge CLOCK); #2; end
        rst = 1'b1;
        @(negedge CLOCK);
        checks += 2;
        if (dout !== '0 || sout !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out: dout=%b sout=%b expected 0 0", dout, sout);
        end
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ctl: done=%b ready=%b expected 0 1", done, cmd_ready);
        end
        @(negedge CLOCK);
        rst = 1'b0;
        seen = 0;
        repeat (300) begin @(negedge CLOCK); if (done === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_mid_done: %0d done cycles expected 0", seen); end
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < WORDS; w++) exp_trk[c][w] = '0;
        check_tracks("rst_mid");
    endtask

    initial begin
        for (int c = 0; c < NCH; c++)
            for (int w = 0; w < WORDS; w++) exp_trk[c][w] = '0;
        test_reset;
        test_load;
        test_or;
        test_copy_all;
        test_copy_self;
        test_t0_accept;
        test_illegal;
`ifdef IO_LINE_MARKER_EN
        test_marker;
`endif
        test_rst_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
